// File: rtl/maze_path_checker.sv
// maze_path_checker: replays a solver move stream from (0,0)
// against a 16x16 wall image and reports pass or fail with a cause.
module maze_path_checker #(
  parameter int MAX_STEPS = 255,
  parameter int GOAL_X    = 15,
  parameter int GOAL_Y    = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       move_valid,
  input  logic [1:0] move,
  output logic       move_ready,
  input  logic       stream_done,
  output logic       rd_mem,
  output logic [7:0] mem_addr,
  input  logic       mem_dout,
  output logic [3:0] x_o,
  output logic [3:0] y_o,
  output logic [7:0] step_count,
  output logic       busy,
  output logic       pass,
  output logic       fail,
  output logic [1:0] fail_code
);

  localparam logic [7:0] LP_MAX = 8'(MAX_STEPS);
  localparam logic [3:0] LP_GX  = 4'(GOAL_X);
  localparam logic [3:0] LP_GY  = 4'(GOAL_Y);

  localparam logic [1:0] MV_UP    = 2'b00;
  localparam logic [1:0] MV_RIGHT = 2'b01;
  localparam logic [1:0] MV_LEFT  = 2'b10;
  localparam logic [1:0] MV_DOWN  = 2'b11;

  localparam logic [1:0] FC_RANGE = 2'b00;
  localparam logic [1:0] FC_WALL  = 2'b01;
  localparam logic [1:0] FC_INCMP = 2'b10;
  localparam logic [1:0] FC_OVFL  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_CHECK,
    S_READ,
    S_EVAL,
    S_PASS,
    S_FAIL
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [3:0]  r_x;
  logic [3:0]  r_y;
  logic [7:0]  r_steps;
  logic [1:0]  r_move;
  logic [7:0]  r_addr;
  logic        r_wall;
  logic        r_pass;
  logic        r_fail;
  logic [1:0]  r_code;

  logic [4:0]  w_nx;
  logic [4:0]  w_ny;
  logic        w_oob;
  logic        w_ovf;
  logic        w_goal;

  logic        w_clear;
  logic        w_latch;
  logic        w_sample;
  logic        w_step;
  logic        w_pass_set;
  logic        w_fail_set;
  logic [1:0]  w_code;
  logic        w_rd;
  logic        w_ready;
  logic        w_busy;

  // candidate cell, one extra bit so stepping off either edge sets bit 4
  always_comb begin
    w_nx = {1'b0, r_x};
    w_ny = {1'b0, r_y};
    unique case (r_move)
      MV_UP:    w_ny = {1'b0, r_y} - 5'd1;
      MV_RIGHT: w_nx = {1'b0, r_x} + 5'd1;
      MV_LEFT:  w_nx = {1'b0, r_x} - 5'd1;
      MV_DOWN:  w_ny = {1'b0, r_y} + 5'd1;
    endcase
  end

  assign w_oob  = w_nx[4] | w_ny[4];
  assign w_ovf  = (r_steps == LP_MAX);
  assign w_goal = (r_x == LP_GX) && (r_y == LP_GY);

  // next state and per-state control strobes
  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_latch    = 1'b0;
    w_sample   = 1'b0;
    w_step     = 1'b0;
    w_pass_set = 1'b0;
    w_fail_set = 1'b0;
    w_code     = FC_RANGE;
    w_rd       = 1'b0;
    w_ready    = 1'b0;
    w_busy     = 1'b0;
    unique case (r_state)
      S_IDLE, S_PASS, S_FAIL: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        w_busy  = 1'b1;
        w_ready = 1'b1;
        if (move_valid) begin
          w_latch = 1'b1;
          w_next  = S_CHECK;
        end else if (stream_done) begin
          if (w_goal) begin
            w_pass_set = 1'b1;
            w_next     = S_PASS;
          end else begin
            w_fail_set = 1'b1;
            w_code     = FC_INCMP;
            w_next     = S_FAIL;
          end
        end
      end
      S_CHECK: begin
        w_busy = 1'b1;
        if (w_ovf) begin
          w_fail_set = 1'b1;
          w_code     = FC_OVFL;
          w_next     = S_FAIL;
        end else if (w_oob) begin
          w_fail_set = 1'b1;
          w_code     = FC_RANGE;
          w_next     = S_FAIL;
        end else begin
          w_rd   = 1'b1;
          w_next = S_READ;
        end
      end
      S_READ: begin
        w_busy   = 1'b1;
        w_sample = 1'b1;
        w_next   = S_EVAL;
      end
      S_EVAL: begin
        w_busy = 1'b1;
        if (r_wall) begin
          w_fail_set = 1'b1;
          w_code     = FC_WALL;
          w_next     = S_FAIL;
        end else begin
          w_step = 1'b1;
          w_next = S_WAIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // position, counters, read address and sticky verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_steps <= '0;
      r_move  <= '0;
      r_addr  <= '0;
      r_wall  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
      r_code  <= '0;
    end else begin
      if (w_clear) begin
        r_x     <= '0;
        r_y     <= '0;
        r_steps <= '0;
        r_pass  <= 1'b0;
        r_fail  <= 1'b0;
        r_code  <= '0;
      end
      if (w_latch) begin
        r_move <= move;
      end
      if (w_rd) begin
        r_addr <= {w_ny[3:0], w_nx[3:0]};
      end
      if (w_sample) begin
        r_wall <= mem_dout;
      end
      if (w_step) begin
        r_x     <= w_nx[3:0];
        r_y     <= w_ny[3:0];
        r_steps <= r_steps + 8'd1;
      end
      if (w_pass_set) begin
        r_pass <= 1'b1;
      end
      if (w_fail_set) begin
        r_fail <= 1'b1;
        r_code <= w_code;
      end
    end
  end

  assign move_ready = w_ready;
  assign busy       = w_busy;
  assign rd_mem     = w_rd;
  assign mem_addr   = w_rd ? {w_ny[3:0], w_nx[3:0]} : r_addr;
  assign x_o        = r_x;
  assign y_o        = r_y;
  assign step_count = r_steps;
  assign pass       = r_pass;
  assign fail       = r_fail;
  assign fail_code  = r_code;

endmodule

// File: tb/tb_maze_path_checker.sv
// tb_maze_path_checker: two checkers (MAX_STEPS 255 and 4) driven
// with directed and random streams, scored against a path model.
module tb_maze_path_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       st[2];
  logic       mvv[2];
  logic [1:0] mv[2];
  logic       sdone[2];
  logic       rdy[2];
  logic       rd[2];
  logic [7:0] addr[2];
  logic       mdo[2];
  logic [3:0] xo[2];
  logic [3:0] yo[2];
  logic [7:0] stc[2];
  logic       bsy[2];
  logic       ps[2];
  logic       fl[2];
  logic [1:0] fc[2];

  bit         wall[256];
  int         rd_cnt[2];
  int         n_chk = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  maze_path_checker u_dut0 (
    .clk(clk), .rst(rst), .start(st[0]),
    .move_valid(mvv[0]), .move(mv[0]),
    .move_ready(rdy[0]), .stream_done(sdone[0]),
    .rd_mem(rd[0]), .mem_addr(addr[0]), .mem_dout(mdo[0]),
    .x_o(xo[0]), .y_o(yo[0]), .step_count(stc[0]),
    .busy(bsy[0]), .pass(ps[0]), .fail(fl[0]),
    .fail_code(fc[0])
  );

  maze_path_checker #(.MAX_STEPS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(st[1]),
    .move_valid(mvv[1]), .move(mv[1]),
    .move_ready(rdy[1]), .stream_done(sdone[1]),
    .rd_mem(rd[1]), .mem_addr(addr[1]), .mem_dout(mdo[1]),
    .x_o(xo[1]), .y_o(yo[1]), .step_count(stc[1]),
    .busy(bsy[1]), .pass(ps[1]), .fail(fl[1]),
    .fail_code(fc[1])
  );

  // wall memory image: registered read, output held until next read
  always @(posedge clk) begin
    if (rd[0]) begin
      mdo[0] <= wall[addr[0]];
      rd_cnt[0] = rd_cnt[0] + 1;
    end
    if (rd[1]) begin
      mdo[1] <= wall[addr[1]];
      rd_cnt[1] = rd_cnt[1] + 1;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input int k,
                     input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s%0d got %0d exp %0d", tag, k, got, exp);
    end
  endtask

  // path model: walk the move list by the rules, first error wins
  function automatic void model(input int q[$], input int mx,
                                output int ex, output int ey,
                                output int es, output int ep,
                                output int ef, output int ec,
                                output int er);
    int x, y, s, nx, ny;
    bit done;
    x = 0; y = 0; s = 0; done = 0;
    ep = 0; ef = 0; ec = 0; er = 0;
    foreach (q[i]) begin
      if (!done) begin
        if (s == mx) begin
          ef = 1; ec = 3; done = 1;
        end else begin
          nx = x; ny = y;
          case (q[i])
            0: ny = y - 1;
            1: nx = x + 1;
            2: nx = x - 1;
            default: ny = y + 1;
          endcase
          if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
            ef = 1; ec = 0; done = 1;
          end else begin
            er++;
            if (wall[ny * 16 + nx]) begin
              ef = 1; ec = 1; done = 1;
            end else begin
              x = nx; y = ny; s++;
            end
          end
        end
      end
    end
    if (!done) begin
      if (x == 15 && y == 15) ep = 1;
      else begin ef = 1; ec = 2; end
    end
    ex = x; ey = y; es = s;
  endfunction

  function automatic int cell_after(input int q[$], input int n);
    int x, y;
    x = 0; y = 0;
    for (int i = 0; i < n; i++) begin
      case (q[i])
        0: y--;
        1: x++;
        2: x--;
        default: y++;
      endcase
    end
    return y * 16 + x;
  endfunction

  task automatic clr_walls();
    foreach (wall[i]) wall[i] = 1'b0;
  endtask

  task automatic chk_zero(input int k, input string p);
    chk({p, "_x"}, k, xo[k], 0);
    chk({p, "_y"}, k, yo[k], 0);
    chk({p, "_st"}, k, stc[k], 0);
    chk({p, "_rdy"}, k, rdy[k], 0);
    chk({p, "_rd"}, k, rd[k], 0);
    chk({p, "_ad"}, k, addr[k], 0);
    chk({p, "_bsy"}, k, bsy[k], 0);
    chk({p, "_ps"}, k, ps[k], 0);
    chk({p, "_fl"}, k, fl[k], 0);
    chk({p, "_fc"}, k, fc[k], 0);
  endtask

  // feed one stream into checker k with random idle gaps
  task automatic drive(input int k, input int q[$],
                       input bit both, input bit poke);
    int n, lat;
    bit alive;
    alive = 1;
    foreach (q[i]) begin
      if (alive) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        mvv[k] = 1'b1;
        mv[k]  = 2'(q[i]);
        sdone[k] = both && (i == q.size() - 1);
        n = 0;
        while (!rdy[k] && n < 20) begin
          @(negedge clk);
          n++;
        end
        if (!rdy[k]) begin
          chk("tmo_rdy", k, 1, 0);
          alive = 0;
          mvv[k] = 1'b0;
        end else begin
          @(posedge clk);
          lat = 0;
          do begin
            @(negedge clk);
            lat++;
            if (poke && i == 0) st[k] = (lat == 1);
          end while (!rdy[k] && bsy[k] && lat < 20);
          st[k] = 1'b0;
          mvv[k] = 1'b0;
          if (rdy[k]) begin
            chk("lat", k, lat, 4);
          end else begin
            if (bsy[k]) chk("tmo_lat", k, 1, 0);
            alive = 0;
          end
        end
      end
    end
    if (alive) begin
      sdone[k] = 1'b1;
      n = 0;
      while (bsy[k] && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (bsy[k]) chk("tmo_done", k, 1, 0);
    end
    sdone[k] = 1'b0;
    mvv[k] = 1'b0;
  endtask

  task automatic run_case(input int q[$], input bit both,
                          input bit poke);
    int ex, ey, es, ep, ef, ec, er;
    int base[2];
    base[0] = rd_cnt[0];
    base[1] = rd_cnt[1];
    @(negedge clk);
    st[0] = 1'b1; st[1] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0; st[1] = 1'b0;
    fork
      drive(0, q, both, poke);
      drive(1, q, both, poke);
    join
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      model(q, (k == 0) ? 255 : 4, ex, ey, es, ep, ef, ec, er);
      chk("x", k, xo[k], ex);
      chk("y", k, yo[k], ey);
      chk("steps", k, stc[k], es);
      chk("pass", k, ps[k], ep);
      chk("fail", k, fl[k], ef);
      if (ef != 0) chk("code", k, fc[k], ec);
      chk("busy", k, bsy[k], 0);
      chk("reads", k, rd_cnt[k] - base[k], er);
    end
  endtask

  initial begin
    int q[$];
    int mode, len, ones, threes, j;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      st[k] = 1'b0; mvv[k] = 1'b0;
      mv[k] = 2'b00; sdone[k] = 1'b0;
      rd_cnt[k] = 0;
    end
    clr_walls();
    #2;
    chk_zero(0, "rst");
    chk_zero(1, "rst");
    @(negedge clk);
    rst = 1'b1;

    q.delete();
    repeat (15) q.push_back(1);
    repeat (15) q.push_back(3);
    run_case(q, 0, 0);

    wall[2] = 1'b1;
    q.delete();
    q.push_back(1); q.push_back(1);
    run_case(q, 0, 1);
    clr_walls();

    q.delete();
    q.push_back(0);
    run_case(q, 0, 0);

    q.delete();
    q.push_back(1); q.push_back(3);
    run_case(q, 0, 0);

    q.delete();
    q.push_back(1); q.push_back(2); q.push_back(1);
    q.push_back(2); q.push_back(1);
    run_case(q, 1, 0);

    @(negedge clk);
    st[0] = 1'b1; st[1] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0; st[1] = 1'b0;
    mvv[0] = 1'b1; mvv[1] = 1'b1;
    mv[0] = 2'b01; mv[1] = 2'b01;
    repeat (4) @(negedge clk);
    mv[0] = 2'b11; mv[1] = 2'b11;
    repeat (2) @(negedge clk);
    mvv[0] = 1'b0; mvv[1] = 1'b0;
    chk("pre_bsy", 0, bsy[0], 1);
    chk("pre_x", 0, xo[0], 1);
    chk("pre_rd", 0, rd[0], 0);
    chk("pre_ad", 0, addr[0], 8'h11);
    #2;
    rst = 1'b0;
    #1;
    chk_zero(0, "mrst");
    chk_zero(1, "mrst");
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    q.push_back(1); q.push_back(3);
    run_case(q, 1, 0);

    for (int t = 0; t < 30; t++) begin
      mode = $urandom_range(0, 2);
      q.delete();
      if (mode == 0) begin
        foreach (wall[i]) wall[i] = ($urandom_range(0, 7) == 0);
        len = $urandom_range(0, 30);
        repeat (len) q.push_back($urandom_range(0, 3));
      end else begin
        foreach (wall[i]) wall[i] = ($urandom_range(0, 3) == 0);
        ones = 15; threes = 15;
        while (ones + threes > 0) begin
          if (threes == 0 || (ones > 0 && $urandom_range(0, 1) == 1)) begin
            q.push_back(1); ones--;
          end else begin
            q.push_back(3); threes--;
          end
        end
        if ($urandom_range(0, 1) == 1) begin
          q.push_back(2); q.push_back(1);
        end
        for (int i = 1; i <= q.size(); i++)
          wall[cell_after(q, i)] = 1'b0;
        if (mode == 2) begin
          j = $urandom_range(1, q.size());
          wall[cell_after(q, j)] = 1'b1;
        end
      end
      run_case(q, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/maze_path_checker.md
Name: maze_path_checker

Overview:
- Consumes the move stream produced by the maze solver (one 2-bit move per handshake) and replays it from cell (0,0).
- Checks every step against the same 16x16 wall memory format the solver uses. Reports pass when the stream ends at goal cell (15,15), or fail with a cause code.
- Sits downstream of the solver's move/done outputs. Shares a read port onto a wall memory image.

Parameters:
- MAX_STEPS, 255: maximum number of accepted moves; must be 255 or less.
- GOAL_X, 15: goal column.
- GOAL_Y, 15: goal row.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a check from (0,0)
- move_valid  in  1  move on move is valid
- move  in  2  00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1)
- move_ready  out  1  checker accepts a move this cycle
- stream_done  in  1  level; solver has no more moves
- rd_mem  out  1  wall memory read strobe
- mem_addr  out  8  {y,x} of the cell being read
- mem_dout  in  1  wall bit, valid the cycle after rd_mem; 1 = wall
- x_o  out  4  current column
- y_o  out  4  current row
- step_count  out  8  accepted legal moves
- busy  out  1  check in progress
- pass  out  1  sticky; path reached goal
- fail  out  1  sticky; path rejected
- fail_code  out  2  00 out of range, 01 wall, 10 incomplete, 11 overflow; valid only while fail=1

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs are 0: x_o, y_o, step_count, move_ready, rd_mem, mem_addr, busy, pass, fail, fail_code.
- States: IDLE, WAIT, CHECK, READ, EVAL, PASS, FAIL.
- IDLE, PASS, FAIL: on start=1, clear x, y, step_count, pass, fail and fail_code, then go to WAIT. Otherwise hold. PASS and FAIL keep their outputs until start or reset.
- WAIT:
  - busy=1, move_ready=1.
  - If move_valid=1: latch move and go to CHECK. The move takes priority over stream_done in the same cycle.
  - Else if stream_done=1: go to PASS if (x,y)=(GOAL_X,GOAL_Y), else go to FAIL with code 10.
- CHECK:
  - move_ready=0.
  - If step_count=MAX_STEPS: FAIL, code 11.
  - Compute the next cell with 5-bit signed arithmetic. x-1 from 0, y-1 from 0, x+1 from 15 or y+1 from 15 is out of range: FAIL, code 00. No wrap-around.
  - Otherwise drive rd_mem=1 and mem_addr={ny,nx} for one cycle, then go to READ.
- READ: rd_mem=0; mem_addr held; wait one cycle.
- EVAL:
  - Sample mem_dout. If 1: FAIL, code 01; x and y are unchanged.
  - Else x,y take the new cell, step_count increments, and the state returns to WAIT.
- Latency: 4 cycles per accepted move (WAIT to CHECK to READ to EVAL). Next move_ready is asserted in the 4th cycle after acceptance.
- Reaching the goal does not end the check. Further moves are processed normally; the decision is made only at stream_done.
- Origin (0,0) is not read from memory.
- start while busy=1: ignored.
- move_valid outside WAIT: ignored. The producer must hold the move until move_ready=1.
- rst asserted mid-check: immediate return to IDLE with all outputs cleared. Any pending memory read is abandoned.

Test Plan:
- Straight path, empty memory: 15x move 01 then 15x move 11, then stream_done. Required: pass=1, fail=0, x_o=15, y_o=15, step_count=30, busy=0.
- Wall hit: memory bit {y=0,x=2}=1; moves 01, 01. Required: fail=1, fail_code=01, x_o=1, y_o=0, step_count=1.
- Range error: first move 00 from (0,0). Required: fail=1, fail_code=00, step_count=0, and no rd_mem pulse.
- Incomplete path: moves 01, 11 then stream_done. Required: fail=1, fail_code=10, x_o=1, y_o=1.
- Overflow (MAX_STEPS=4): moves 01, 10, 01, 10, 01. Required: fail=1, fail_code=11, step_count=4. Also check that move_valid and stream_done asserted together in WAIT result in the move being processed first.
- Reset mid-check: rst=0 during READ. Required: all outputs 0 asynchronously. Then start with a 2-move path ending in stream_done produces a clean result.
